dmem_responder: RTL and testbench
=================================

DMEM_RESPONDER -- requirements
Module: dmem_responder

Interface
REQ-001 The block SHALL have parameter DEPTH_LOG2, default 10, meaning log2 of the number of 64-bit words stored.
REQ-002 The block SHALL have parameter LATENCY, default 2, meaning the number of cycles from request acceptance to response (legal range 1..15).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: the reset, asynchronous and active-low.
REQ-005 The block SHALL have port mem_ce_i, input, 1 bit: request valid from the memory-access stage.
REQ-006 The block SHALL have port mem_we_i, input, 1 bit: 1 = write request, 0 = read request.
REQ-007 The block SHALL have port mem_raddr_i, input, 64 bits: read byte address.
REQ-008 The block SHALL have port mem_waddr_i, input, 64 bits: write byte address.
REQ-009 The block SHALL have port mem_wdata_i, input, 64 bits: full merged write word.
REQ-010 The block SHALL have port mem_rdata_o, output, 64 bits: response data word.
REQ-011 The block SHALL have port rvalid_o, output, 1 bit: response valid, one-cycle pulse.
REQ-012 The block SHALL have port hold_flag_o, output, 1 bit: pipeline stall request to the requester.

Function
REQ-013 The FSM SHALL have exactly three states: IDLE, BUSY, RESP.
REQ-014 In IDLE with mem_ce_i=1 (cycle T), the request SHALL be accepted: we, word address and wdata latched, FSM to BUSY (LATENCY>=2) or RESP (LATENCY=1).
REQ-015 The word index SHALL be addr[DEPTH_LOG2+2:3]: bits [2:0] ignored, bits above the index ignored (aliasing wrap-around).
REQ-016 A write SHALL use mem_waddr_i; a read SHALL use mem_raddr_i; with mem_we_i=1 mem_raddr_i SHALL be ignored.
REQ-017 A 4-bit down-counter SHALL load LATENCY-2 on entry to BUSY, with BUSY→RESP when it reaches 0; rvalid_o SHALL be 1 in exactly cycle T+LATENCY.
REQ-018 hold_flag_o SHALL be 1 combinationally in the acceptance cycle (IDLE and mem_ce_i) and throughout BUSY, and SHALL be 0 in RESP and in idle IDLE.
REQ-019 In RESP, mem_rdata_o SHALL present the word stored at the latched index before any write of this request (old data for writes, enabling requester merge).
REQ-020 A write SHALL commit to the array on the rising edge ending the RESP cycle.
REQ-021 RESP SHALL always go to IDLE; mem_ce_i asserted during RESP SHALL be ignored (the requester's request is still the completed one).
REQ-022 mem_ce_i changes during BUSY SHALL be ignored; latched values SHALL govern.
REQ-023 mem_rdata_o SHALL hold its last response value until the next RESP.
REQ-024 Back-to-back requests SHALL complete at one per LATENCY+1 cycles minimum.

Reset
REQ-025 While rst_n=0: FSM=IDLE, counter=0, mem_rdata_o=0, rvalid_o=0, hold_flag_o=0.
REQ-026 Reset asserted mid-operation SHALL abort the request; a pending write SHALL NOT commit.
REQ-027 Array contents SHALL NOT be reset.

Configuration
REQ-028 Macro DMEM_WSTRB_EN defined: an extra input port mem_wstrb_i, 8 bits, latched at acceptance, is present; only bytes whose strobe bit is 1 are written.
REQ-029 Macro DMEM_WSTRB_EN undefined: mem_wstrb_i is absent and every write updates all 8 bytes.

Verification
REQ-030 LATENCY=2: write 0x1122334455667788 to 0x80, then read 0x80 -> hold_flag_o high 2 cycles per request, rvalid_o at T+2, read returns 0x1122334455667788.
REQ-031 Write 0xAAAA to 0x88 over a word previously 0x5555 -> RESP mem_rdata_o=0x5555; a subsequent read returns 0xAAAA.
REQ-032 DEPTH_LOG2=10: write to 0x2008, read 0x0008 -> aliasing returns the written word; read 0x000F returns the same word.
REQ-033 rst_n pulsed low during BUSY of a write to 0x100 -> outputs 0 immediately; a later read of 0x100 returns the old value.
REQ-034 LATENCY=1: continuous mem_ce_i -> rvalid_o every 2nd cycle, hold_flag_o pattern 1,0,1,0.
REQ-035 DMEM_WSTRB_EN, strobe 0x0F, wdata 0xFFFFFFFFFFFFFFFF over 0 -> read returns 0x00000000FFFFFFFF.

Source files
------------

// File: rtl/dmem_responder.sv
// dmem_responder
//   Single-requester data-memory responder. A request seen in IDLE is latched,
//   a response is produced LATENCY cycles later, and a write then commits.
//   The response always carries the word that was stored before the write,
//   so the requester can merge partial data.
//
//   Parameters
//     DEPTH_LOG2 : log2 of the number of 64-bit words in the array
//     LATENCY    : cycles from acceptance to rvalid_o (1..15)
//
//   Ports
//     clk, rst_n   : clock, async active-low reset
//     mem_ce_i     : request valid (sampled only in IDLE)
//     mem_we_i     : 1 = write, 0 = read
//     mem_raddr_i  : read byte address
//     mem_waddr_i  : write byte address
//     mem_wdata_i  : write word
//     mem_wstrb_i  : byte write strobes (only with DMEM_WSTRB_EN defined)
//     mem_rdata_o  : response word (pre-write contents), held until next response
//     rvalid_o     : one-cycle response pulse
//     hold_flag_o  : stall request to the requester
//
//   Build option: define DMEM_WSTRB_EN to add mem_wstrb_i byte strobes;
//   without it every write updates all 8 bytes.

module dmem_byte_lane #(
  parameter int VEC_W = 8
) (
  input  logic             sel,
  input  logic [VEC_W-1:0] old_b,
  input  logic [VEC_W-1:0] new_b,
  output logic [VEC_W-1:0] out_b
);
  assign out_b = sel ? new_b : old_b;
endmodule

module dmem_responder #(
  parameter int DEPTH_LOG2 = 10,
  parameter int LATENCY    = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        mem_ce_i,
  input  logic        mem_we_i,
  input  logic [63:0] mem_raddr_i,
  input  logic [63:0] mem_waddr_i,
  input  logic [63:0] mem_wdata_i,
`ifdef DMEM_WSTRB_EN
  input  logic [7:0]  mem_wstrb_i,
`endif
  output logic [63:0] mem_rdata_o,
  output logic        rvalid_o,
  output logic        hold_flag_o
);
  localparam int NUM_LANES = 8;
  localparam int VEC_W     = 8;
  localparam int WORDS     = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  typedef struct packed {
    logic                  we;
    logic [DEPTH_LOG2-1:0] idx;
    logic [63:0]           wdata;
    logic [NUM_LANES-1:0]  wstrb;
  } req_t;

  state_t      state;
  logic [3:0]  cnt;
  req_t        req_q, req_in;
  logic [63:0] mem [WORDS];

  logic accept;
  assign accept = (state == IDLE) && mem_ce_i;

  // Word index drops the byte offset; upper address bits alias.
  always_comb begin
    req_in       = '0;
    req_in.we    = mem_we_i;
    req_in.idx   = mem_we_i ? mem_waddr_i[DEPTH_LOG2+2:3] : mem_raddr_i[DEPTH_LOG2+2:3];
    req_in.wdata = mem_wdata_i;
`ifdef DMEM_WSTRB_EN
    req_in.wstrb = mem_wstrb_i;
`else
    req_in.wstrb = '1;
`endif
  end

  // Gated by rst_n so the stall is low while reset is held even if ce is high.
  assign hold_flag_o = rst_n && (accept || (state == BUSY));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      cnt         <= '0;
      rvalid_o    <= 1'b0;
      mem_rdata_o <= '0;
      req_q       <= '0;
    end else begin
      rvalid_o <= 1'b0;
      case (state)
        IDLE: if (mem_ce_i) begin
          req_q <= req_in;
          if (LATENCY <= 1) begin
            state       <= RESP;
            rvalid_o    <= 1'b1;
            mem_rdata_o <= mem[req_in.idx];
          end else begin
            state <= BUSY;
            cnt   <= 4'(LATENCY - 2);
          end
        end
        BUSY: begin
          if (cnt == 4'd0) begin
            state       <= RESP;
            rvalid_o    <= 1'b1;
            mem_rdata_o <= mem[req_q.idx];
          end else begin
            cnt <= cnt - 4'd1;
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // During RESP mem_rdata_o holds the pre-write word, so it doubles as the
  // old-data source for the byte merge.
  logic [NUM_LANES-1:0][VEC_W-1:0] old_lanes, new_lanes, wr_lanes;
  assign old_lanes = mem_rdata_o;
  assign new_lanes = req_q.wdata;

  for (genvar l = 0; l < NUM_LANES; l++) begin : g_lane
    dmem_byte_lane #(.VEC_W(VEC_W)) u_lane (
      .sel   (req_q.wstrb[l]),
      .old_b (old_lanes[l]),
      .new_b (new_lanes[l]),
      .out_b (wr_lanes[l])
    );
  end

  // Array is not reset; a reset before the RESP edge drops the write.
  always_ff @(posedge clk) begin
    if (state == RESP && req_q.we)
      mem[req_q.idx] <= wr_lanes;
  end

  logic unused_bits;
  assign unused_bits = ^{mem_raddr_i[63:DEPTH_LOG2+3], mem_raddr_i[2:0],
                         mem_waddr_i[63:DEPTH_LOG2+3], mem_waddr_i[2:0]};
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
  localparam int LAT = 2;
`ifdef DMEM_WSTRB_EN
  localparam bit HAS_WSTRB = 1'b1;
`else
  localparam bit HAS_WSTRB = 1'b0;
`endif

  logic clk = 1'b0, rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        ce0 = 0, we0 = 0, ce1 = 0, we1 = 0;
  logic [63:0] ra0 = 0, wa0 = 0, wd0 = 0, ra1 = 0, wa1 = 0, wd1 = 0;
  logic [7:0]  st0 = 8'hFF, st1 = 8'hFF;
  logic [63:0] rd0, rd1;
  logic        rv0, hf0, rv1, hf1;

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(LAT)) dut (
    .clk(clk), .rst_n(rst_n), .mem_ce_i(ce0), .mem_we_i(we0),
    .mem_raddr_i(ra0), .mem_waddr_i(wa0), .mem_wdata_i(wd0),
`ifdef DMEM_WSTRB_EN
    .mem_wstrb_i(st0),
`endif
    .mem_rdata_o(rd0), .rvalid_o(rv0), .hold_flag_o(hf0));

  dmem_responder #(.DEPTH_LOG2(10), .LATENCY(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .mem_ce_i(ce1), .mem_we_i(we1),
    .mem_raddr_i(ra1), .mem_waddr_i(wa1), .mem_wdata_i(wd1),
`ifdef DMEM_WSTRB_EN
    .mem_wstrb_i(st1),
`endif
    .mem_rdata_o(rd1), .rvalid_o(rv1), .hold_flag_o(hf1));

  int vectors = 0, miscompares = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference memories: word index -> contents; absent means never written.
  bit [63:0] model0 [int];
  bit [63:0] model1 [int];

  // Applies one request to the reference: returns the pre-write word and
  // whether it is known, then applies the write with byte strobes.
  task automatic ref_access(input bit which, input bit we, input logic [63:0] ra, wa, wd,
                            input logic [7:0] st, output bit [63:0] exp, output bit known);
    logic [63:0] a = we ? wa : ra;
    int i = int'(a[12:3]);
    bit [7:0]  st_eff = HAS_WSTRB ? st : 8'hFF;
    bit [63:0] mask = '0;
    bit [63:0] nw;
    for (int b = 0; b < 8; b++) if (st_eff[b]) mask[b*8 +: 8] = 8'hFF;
    known = which ? model1.exists(i) : model0.exists(i);
    exp   = known ? (which ? model1[i] : model0[i]) : 64'h0;
    if (we) begin
      nw = (exp & ~mask) | (wd & mask);
      if (known || st_eff == 8'hFF) begin
        if (which) model1[i] = nw; else model0[i] = nw;
      end
    end
  endtask

  // Drives one request on the LATENCY=2 instance and records what it saw.
  // Between acceptance and completion the inputs are scrambled; they must be ignored.
  task automatic run0(input bit we, input logic [63:0] ra, wa, wd, input logic [7:0] st,
                      output logic [63:0] rd, output int rv_at, output int hold_n,
                      output bit idle_bad, output bit [63:0] exp, output bit known);
    ref_access(1'b0, we, ra, wa, wd, st, exp, known);
    ce0 = 1; we0 = we; ra0 = ra; wa0 = wa; wd0 = wd; st0 = st;
    rv_at = 0; hold_n = 0; rd = '0;
    @(negedge clk);
    if (hf0) hold_n++;
    if (rv0) rv_at = -1;
    for (int k = 1; k <= LAT; k++) begin
      @(posedge clk); #1;
      ce0 = 1'($urandom); we0 = 1'($urandom);
      ra0 = {$urandom, $urandom}; wa0 = {$urandom, $urandom};
      wd0 = {$urandom, $urandom}; st0 = 8'($urandom);
      @(negedge clk);
      if (hf0) hold_n++;
      if (rv0) begin
        rv_at = (rv_at == 0) ? k : -1;
        rd = rd0;
      end
    end
    @(posedge clk); #1;
    ce0 = 0;
    #1 idle_bad = hf0 || rv0;
  endtask

  task automatic test_reset();
    rst_n = 0; ce0 = 1; ce1 = 1;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (rd0 !== 64'h0) begin miscompares++; $display("FAIL reset_rdata0 got %h want 0", rd0); end
    vectors++; if (rv0 !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid0 got %b want 0", rv0); end
    vectors++; if (hf0 !== 1'b0) begin miscompares++; $display("FAIL reset_hold0 got %b want 0", hf0); end
    vectors++; if (rd1 !== 64'h0) begin miscompares++; $display("FAIL reset_rdata1 got %h want 0", rd1); end
    vectors++; if (rv1 !== 1'b0) begin miscompares++; $display("FAIL reset_rvalid1 got %b want 0", rv1); end
    vectors++; if (hf1 !== 1'b0) begin miscompares++; $display("FAIL reset_hold1 got %b want 0", hf1); end
    ce0 = 0; ce1 = 0;
    @(posedge clk); #1 rst_n = 1;
    @(posedge clk); #1;
  endtask

  task automatic test_basic();
    logic [63:0] rd; int rv_at, hn; bit ib, kn; bit [63:0] ex;
    run0(1, {$urandom, $urandom}, 64'h80, 64'h1122334455667788, 8'hFF, rd, rv_at, hn, ib, ex, kn);
    vectors++; if (hn !== LAT) begin miscompares++; $display("FAIL basic_wr_hold got %0d want %0d", hn, LAT); end
    vectors++; if (rv_at !== LAT) begin miscompares++; $display("FAIL basic_wr_rvalid_cycle got %0d want %0d", rv_at, LAT); end
    vectors++; if (ib) begin miscompares++; $display("FAIL basic_wr_idle got 1 want 0"); end
    run0(0, 64'h80, {$urandom, $urandom}, {$urandom, $urandom}, 8'hFF, rd, rv_at, hn, ib, ex, kn);
    vectors++; if (hn !== LAT) begin miscompares++; $display("FAIL basic_rd_hold got %0d want %0d", hn, LAT); end
    vectors++; if (rv_at !== LAT) begin miscompares++; $display("FAIL basic_rd_rvalid_cycle got %0d want %0d", rv_at, LAT); end
    vectors++; if (rd !== 64'h1122334455667788) begin miscompares++; $display("FAIL basic_rd_data got %h want 1122334455667788", rd); end
  endtask

  task automatic test_old_data();
    logic [63:0] rd; int rv_at, hn; bit ib, kn; bit [63:0] ex;
    run0(1, 64'h0, 64'h88, 64'h5555, 8'hFF, rd, rv_at, hn, ib, ex, kn);
    run0(1, 64'h0, 64'h88, 64'hAAAA, 8'hFF, rd, rv_at, hn, ib, ex, kn);
    vectors++; if (rd !== 64'h5555) begin miscompares++; $display("FAIL olddata_resp got %h want 5555", rd); end
    run0(0, 64'h88, 64'h0, 64'h0, 8'hFF, rd, rv_at, hn, ib, ex, kn);
    vectors++; if (rd !== 64'hAAAA) begin miscompares++; $display("FAIL olddata_readback got %h want aaaa", rd); end
  endtask

  task automatic test_alias();
    logic [63:0] rd; int rv_at, hn; bit ib, kn; bit [63:0] ex;
    logic [63:0] v = {$urandom, $urandom};
    run0(1, 64'h0, 64'h2008, v, 8'hFF, rd, rv_at, hn, ib, ex, kn);
    run0(0, 64'h0008, 64'h0, 64'h0, 8'hFF, rd, rv_at, hn, ib, ex, kn);
    vectors++; if (rd !== v) begin miscompares++; $display("FAIL alias_0008 got %h want %h", rd, v); end
    run0(0, 64'h000F, 64'h0, 64'h0, 8'hFF, rd, rv_at, hn, ib, ex, kn);
    vectors++; if (rd !== v) begin miscompares++; $display("FAIL alias_000F got %h want %h", rd, v); end
  endtask

  task automatic test_reset_abort();
    logic [63:0] rd; int rv_at, hn; bit ib, kn; bit [63:0] ex;
    run0(1, 64'h0, 64'h100, 64'hC0FFEE0012345678, 8'hFF, rd, rv_at, hn, ib, ex, kn);
    ce0 = 1; we0 = 1; wa0 = 64'h100; wd0 = 64'hDEADBEEFDEADBEEF; st0 = 8'hFF;
    @(posedge clk); #1;          // now in BUSY
    ce0 = 1;                     // stall must still drop under reset
    rst_n = 0;
    #1;
    vectors++; if (rd0 !== 64'h0) begin miscompares++; $display("FAIL abort_rdata got %h want 0", rd0); end
    vectors++; if (rv0 !== 1'b0) begin miscompares++; $display("FAIL abort_rvalid got %b want 0", rv0); end
    vectors++; if (hf0 !== 1'b0) begin miscompares++; $display("FAIL abort_hold got %b want 0", hf0); end
    ce0 = 0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    @(posedge clk); #1;
    run0(0, 64'h100, 64'h0, 64'h0, 8'hFF, rd, rv_at, hn, ib, ex, kn);
    vectors++; if (rd !== 64'hC0FFEE0012345678) begin miscompares++; $display("FAIL abort_readback got %h want c0ffee0012345678", rd); end
    vectors++; if (rv_at !== LAT) begin miscompares++; $display("FAIL abort_rvalid_cycle got %0d want %0d", rv_at, LAT); end
  endtask

  task automatic test_random();
    logic [63:0] rd, ra, wa; int rv_at, hn; bit ib, kn; bit [63:0] ex;
    for (int n = 0; n < 40; n++) begin
      ra = {$urandom, $urandom}; wa = {$urandom, $urandom};
      ra[12:3] = 10'($urandom_range(15, 0)); wa[12:3] = 10'($urandom_range(15, 0));
      run0(1'($urandom), ra, wa, {$urandom, $urandom}, 8'($urandom), rd, rv_at, hn, ib, ex, kn);
      vectors++; if (hn !== LAT || rv_at !== LAT || ib) begin
        miscompares++; $display("FAIL rand_timing[%0d] got hold=%0d rv=%0d idle_bad=%0b want hold=%0d rv=%0d", n, hn, rv_at, ib, LAT, LAT);
      end
      if (kn) begin
        vectors++; if (rd !== ex) begin miscompares++; $display("FAIL rand_data[%0d] got %h want %h", n, rd, ex); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [63:0] rd; int rv_at, hn; bit ib, kn; bit [63:0] ex;
    int c0, c1;
    c0 = cyc;
    for (int n = 0; n < 5; n++)
      run0(1'($urandom), {$urandom, $urandom}, {$urandom, $urandom}, {$urandom, $urandom}, 8'hFF, rd, rv_at, hn, ib, ex, kn);
    c1 = cyc;
    vectors++; if (c1 - c0 !== 5 * (LAT + 1)) begin miscompares++; $display("FAIL b2b_cycles got %0d want %0d", c1 - c0, 5 * (LAT + 1)); end
  endtask

  task automatic test_lat1();
    bit [63:0] ex; bit kn;
    for (int k = 0; k < 16; k++) begin
      ce1 = 1; we1 = 1'($urandom);
      ra1 = {$urandom, $urandom}; wa1 = {$urandom, $urandom}; wd1 = {$urandom, $urandom};
      ra1[12:3] = 10'($urandom_range(3, 0)); wa1[12:3] = 10'($urandom_range(3, 0));
      st1 = 8'hFF;
      if (k % 2 == 0) ref_access(1'b1, we1, ra1, wa1, wd1, st1, ex, kn);
      @(negedge clk);
      vectors++; if (hf1 !== (k % 2 == 0)) begin miscompares++; $display("FAIL lat1_hold[%0d] got %b want %b", k, hf1, k % 2 == 0); end
      vectors++; if (rv1 !== (k % 2 == 1)) begin miscompares++; $display("FAIL lat1_rvalid[%0d] got %b want %b", k, rv1, k % 2 == 1); end
      if (k % 2 == 1 && kn) begin
        vectors++; if (rd1 !== ex) begin miscompares++; $display("FAIL lat1_data[%0d] got %h want %h", k, rd1, ex); end
      end
      @(posedge clk); #1;
    end
    ce1 = 0;
    @(posedge clk); #1;
  endtask

  task automatic test_wstrb();
    logic [63:0] rd; int rv_at, hn; bit ib, kn; bit [63:0] ex;
    run0(1, 64'h0, 64'h40, 64'h0, 8'hFF, rd, rv_at, hn, ib, ex, kn);
    run0(1, 64'h0, 64'h40, 64'hFFFFFFFFFFFFFFFF, 8'h0F, rd, rv_at, hn, ib, ex, kn);
    run0(0, 64'h40, 64'h0, 64'h0, 8'hFF, rd, rv_at, hn, ib, ex, kn);
    if (HAS_WSTRB) begin
      vectors++; if (rd !== 64'h00000000FFFFFFFF) begin miscompares++; $display("FAIL wstrb_merge got %h want 00000000ffffffff", rd); end
    end else begin
      vectors++; if (rd !== 64'hFFFFFFFFFFFFFFFF) begin miscompares++; $display("FAIL wstrb_full got %h want ffffffffffffffff", rd); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_old_data();
    test_alias();
    test_reset_abort();
    test_random();
    test_back_to_back();
    test_lat1();
    test_wstrb();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout got running want finished");
    $fatal(1, "timeout");
  end
endmodule
